jts16_ramarb: RTL and testbench

- Arbitrates one shared SDRAM bank slot between two masters: main 68000 work-RAM/VRAM accesses and the i8751 MCU external-bus requests.
- Sits between the main CPU address decoder and the SDRAM controller.
- Serialises requests and enforces the strobe-toggle rule of the memory interface.
- Returns data and completion to each master.

---
 rtl/jts16_ramarb.sv | 138 +++++++++++++
 tb/tb_jts16_ramarb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jts16_ramarb.sv
// Shared SDRAM slot arbiter between the main 68000 bus and the i8751 MCU
// external bus. One access is in flight at a time. A one-cycle gap is kept
// between accesses, and each CPU access requires cpu_cs to toggle.
module jts16_ramarb #(
    parameter int AW   = 17,
    parameter int FAIR = 1
) (
    input  logic          clk,
    input  logic          rst,
    // main CPU side
    input  logic          cpu_cs,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_rnw,
    input  logic [1:0]    cpu_dsn,
    input  logic [15:0]   cpu_din,
    output logic [15:0]   cpu_dout,
    output logic          cpu_ok,
    // MCU side
    input  logic          mcu_req,
    input  logic [AW-1:0] mcu_addr,
    input  logic          mcu_rnw,
    input  logic [1:0]    mcu_dsn,
    input  logic [15:0]   mcu_din,
    output logic [15:0]   mcu_dout,
    output logic          mcu_ack,
    // SDRAM side
    output logic          mem_cs,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rnw,
    output logic [1:0]    mem_dsn,
    output logic [15:0]   mem_din,
    input  logic [15:0]   mem_dout,
    input  logic          mem_ok,
    output logic          busy_mcu
);

    typedef enum logic [1:0] {IDLE, CPU, MCU, GAP} state_t;

    state_t state, state_nxt;
    logic   cpu_done, mcu_pend, last_mcu;
    logic   cpu_elig, mcu_want;
    logic   grant_cpu, grant_mcu, done_ev;

    // A strobe arriving while idle can be granted on its own cycle, which
    // keeps the uncontended MCU latency equal to the CPU one.
    assign cpu_elig = cpu_cs & ~cpu_done & (cpu_dsn != 2'b11);
    assign mcu_want = mcu_pend | mcu_req;
    assign cpu_ok   = cpu_done & cpu_cs;
    assign busy_mcu = (state == MCU);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: grant selection in IDLE, completion detection in service
    always_comb begin
        state_nxt = state;
        grant_cpu = 1'b0;
        grant_mcu = 1'b0;
        done_ev   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_elig && mcu_want) begin
                    if (FAIR != 0 && !last_mcu) grant_mcu = 1'b1;
                    else                        grant_cpu = 1'b1;
                end else if (cpu_elig) begin
                    grant_cpu = 1'b1;
                end else if (mcu_want) begin
                    grant_mcu = 1'b1;
                end
                if (grant_cpu) state_nxt = CPU;
                if (grant_mcu) state_nxt = MCU;
            end
            CPU, MCU: begin
                if (mem_ok) begin
                    done_ev   = 1'b1;
                    state_nxt = GAP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory request registers, per-master bookkeeping and returned data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_cs   <= 1'b0;
            mem_addr <= '0;
            mem_rnw  <= 1'b0;
            mem_dsn  <= '1;
            mem_din  <= '0;
            cpu_dout <= '0;
            mcu_dout <= '0;
            mcu_ack  <= 1'b0;
            cpu_done <= 1'b0;
            mcu_pend <= 1'b0;
            last_mcu <= 1'b1;
        end else begin
            mcu_ack <= 1'b0;
            if (mcu_req && !mcu_pend && state != MCU) mcu_pend <= 1'b1;
            if (!cpu_cs) cpu_done <= 1'b0;

            if (grant_cpu) begin
                mem_cs   <= 1'b1;
                mem_addr <= cpu_addr;
                mem_rnw  <= cpu_rnw;
                mem_dsn  <= cpu_dsn;
                mem_din  <= cpu_din;
            end else if (grant_mcu) begin
                mem_cs   <= 1'b1;
                mem_addr <= mcu_addr;
                mem_rnw  <= mcu_rnw;
                mem_dsn  <= mcu_dsn;
                mem_din  <= mcu_din;
            end

            if (done_ev) begin
                mem_cs   <= 1'b0;
                last_mcu <= (state == MCU);
                if (state == CPU) begin
                    // An aborted CPU access still finishes on the bus but
                    // returns nothing to the CPU.
                    if (cpu_cs) begin
                        cpu_done <= 1'b1;
                        if (mem_rnw) cpu_dout <= mem_dout;
                    end
                end else begin
                    mcu_ack  <= 1'b1;
                    mcu_pend <= 1'b0;
                    if (mem_rnw) mcu_dout <= mem_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_jts16_ramarb.sv
// Directed bench for jts16_ramarb: one FAIR=1 and one FAIR=0 instance share
// the master-side stimulus; each has its own simple SDRAM responder.
`timescale 1ns/1ps
module tb_jts16_ramarb;
    localparam int AW  = 17;
    localparam int LAT = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          cpu_cs   = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_rnw  = 1'b1;
    logic [1:0]    cpu_dsn  = 2'b11;
    logic [15:0]   cpu_din  = '0;
    logic          mcu_req  = 1'b0;
    logic [AW-1:0] mcu_addr = '0;
    logic          mcu_rnw  = 1'b1;
    logic [1:0]    mcu_dsn  = 2'b11;
    logic [15:0]   mcu_din  = '0;
    logic [15:0]   rdata    = '0;

    logic [15:0]   c1_dout, m1_dout, s1_din, c0_dout, m0_dout, s0_din;
    logic          c1_ok, m1_ack, s1_cs, s1_rnw, b1;
    logic          c0_ok, m0_ack, s0_cs, s0_rnw, b0;
    logic [AW-1:0] s1_addr, s0_addr;
    logic [1:0]    s1_dsn, s0_dsn;
    logic          s1_ok = 1'b0;
    logic          s0_ok = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jts16_ramarb #(.AW(AW), .FAIR(1)) dut1 (
        .clk(clk), .rst(rst),
        .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw), .cpu_dsn(cpu_dsn),
        .cpu_din(cpu_din), .cpu_dout(c1_dout), .cpu_ok(c1_ok),
        .mcu_req(mcu_req), .mcu_addr(mcu_addr), .mcu_rnw(mcu_rnw), .mcu_dsn(mcu_dsn),
        .mcu_din(mcu_din), .mcu_dout(m1_dout), .mcu_ack(m1_ack),
        .mem_cs(s1_cs), .mem_addr(s1_addr), .mem_rnw(s1_rnw), .mem_dsn(s1_dsn),
        .mem_din(s1_din), .mem_dout(rdata), .mem_ok(s1_ok), .busy_mcu(b1)
    );

    jts16_ramarb #(.AW(AW), .FAIR(0)) dut0 (
        .clk(clk), .rst(rst),
        .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw), .cpu_dsn(cpu_dsn),
        .cpu_din(cpu_din), .cpu_dout(c0_dout), .cpu_ok(c0_ok),
        .mcu_req(mcu_req), .mcu_addr(mcu_addr), .mcu_rnw(mcu_rnw), .mcu_dsn(mcu_dsn),
        .mcu_din(mcu_din), .mcu_dout(m0_dout), .mcu_ack(m0_ack),
        .mem_cs(s0_cs), .mem_addr(s0_addr), .mem_rnw(s0_rnw), .mem_dsn(s0_dsn),
        .mem_din(s0_din), .mem_dout(rdata), .mem_ok(s0_ok), .busy_mcu(b0)
    );

    // SDRAM responders: mem_ok pulses after mem_cs has been seen high LAT times
    int q1 = 0;
    int q0 = 0;
    always @(negedge clk) begin
        if (rst) begin q1 = 0; s1_ok = 1'b0; end
        else if (s1_ok) begin s1_ok = 1'b0; q1 = 0; end
        else if (s1_cs) begin q1++; if (q1 == LAT) s1_ok = 1'b1; end
    end
    always @(negedge clk) begin
        if (rst) begin q0 = 0; s0_ok = 1'b0; end
        else if (s0_ok) begin s0_ok = 1'b0; q0 = 0; end
        else if (s0_cs) begin q0++; if (q0 == LAT) s0_ok = 1'b1; end
    end

    // Transaction loggers: count mem_cs rises and mcu_ack pulses, note last request
    int n1 = 0, a1 = 0, n0 = 0, a0 = 0;
    logic p1 = 1'b0, p0 = 1'b0;
    logic r1_busy, r1_rnw, r0_busy;
    logic [15:0] r1_din;
    logic [AW-1:0] r1_addr;
    always @(negedge clk) begin
        if (s1_cs && !p1) begin
            n1++; r1_busy = b1; r1_rnw = s1_rnw; r1_din = s1_din; r1_addr = s1_addr;
        end
        p1 = s1_cs;
        if (m1_ack) a1++;
        if (s0_cs && !p0) begin n0++; r0_busy = b0; end
        p0 = s0_cs;
        if (m0_ack) a0++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    initial begin
        int base1, base0, ab1, ab0, hi;
        logic ok;

        // reset values
        tick(2);
        chk("rst_mem_cs", 32'(s1_cs), 0);
        chk("rst_mem_dsn", 32'(s1_dsn), 3);
        chk("rst_mem_dsn0", 32'(s0_dsn), 3);
        chk("rst_cpu_ok", 32'(c1_ok), 0);
        chk("rst_mcu_ack", 32'(m1_ack), 0);
        chk("rst_busy", 32'(b1), 0);
        chk("rst_cpu_dout", 32'(c1_dout), 0);
        rst = 1'b0;
        tick(1);

        // lone CPU read
        cpu_addr = 17'h00123; cpu_rnw = 1'b1; cpu_dsn = 2'b00; cpu_cs = 1'b1; rdata = 16'hBEEF;
        base1 = n1; hi = 0; ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick(1);
            if (s1_cs) hi++;
            if (c1_ok) ok = 1'b1;
        end
        chk("t1_ok_seen", 32'(ok), 1);
        chk("t1_cs_cycles", 32'(hi), 5);
        chk("t1_addr", 32'(r1_addr), 32'h123);
        chk("t1_rnw", 32'(r1_rnw), 1);
        chk("t1_dout", 32'(c1_dout), 32'hBEEF);
        chk("t1_dout0", 32'(c0_dout), 32'hBEEF);
        tick(6);
        chk("t1_single", 32'(n1 - base1), 1);
        chk("t1_ok_hold", 32'(c1_ok), 1);
        cpu_cs = 1'b0;
        #1;
        chk("t1_ok_fall", 32'(c1_ok), 0);
        tick(1);

        // CPU with no byte strobes is not eligible
        cpu_dsn = 2'b11; cpu_cs = 1'b1; base1 = n1;
        tick(6);
        chk("t1b_no_req", 32'(n1 - base1), 0);
        cpu_cs = 1'b0;
        tick(1);

        // lone MCU write, with a stray strobe during service
        mcu_addr = 17'h1F000; mcu_rnw = 1'b0; mcu_dsn = 2'b10; mcu_din = 16'h00A5; mcu_req = 1'b1;
        base1 = n1; ab1 = a1;
        tick(1);
        mcu_req = 1'b0;
        chk("t2_cs", 32'(s1_cs), 1);
        chk("t2_busy", 32'(b1), 1);
        chk("t2_addr", 32'(s1_addr), 32'h1F000);
        chk("t2_rnw", 32'(s1_rnw), 0);
        chk("t2_dsn", 32'(s1_dsn), 2);
        chk("t2_din", 32'(s1_din), 32'h00A5);
        tick(2);
        mcu_addr = 17'h00001; mcu_req = 1'b1;
        tick(1);
        mcu_req = 1'b0;
        tick(20);
        chk("t2_ack_once", 32'(a1 - ab1), 1);
        chk("t2_stray_ignored", 32'(n1 - base1), 1);
        chk("t2_dout_kept", 32'(m1_dout), 0);

        // collision A after reset: both instances serve CPU, then MCU
        rst = 1'b1; tick(1); rst = 1'b0; tick(1);
        cpu_addr = 17'h00010; cpu_rnw = 1'b1; cpu_dsn = 2'b00; cpu_cs = 1'b1;
        mcu_addr = 17'h00020; mcu_rnw = 1'b1; mcu_dsn = 2'b00; mcu_req = 1'b1;
        rdata = 16'h1111; base1 = n1; base0 = n0; ab1 = a1; ab0 = a0;
        tick(1);
        mcu_req = 1'b0;
        chk("cA_f1_first_cpu", 32'(b1), 0);
        chk("cA_f1_addr", 32'(s1_addr), 32'h10);
        chk("cA_f0_first_cpu", 32'(b0), 0);
        tick(30);
        chk("cA_f1_count", 32'(n1 - base1), 2);
        chk("cA_f1_second_mcu", 32'(r1_busy), 1);
        chk("cA_f1_second_addr", 32'(r1_addr), 32'h20);
        chk("cA_f0_count", 32'(n0 - base0), 2);
        chk("cA_f0_second_mcu", 32'(r0_busy), 1);
        chk("cA_f1_ack", 32'(a1 - ab1), 1);
        chk("cA_f0_ack", 32'(a0 - ab0), 1);
        chk("cA_f1_cpu_ok", 32'(c1_ok), 1);
        chk("cA_f1_mcu_dout", 32'(m1_dout), 32'h1111);
        cpu_cs = 1'b0;
        tick(1);

        // lone CPU access so that the CPU was served last
        cpu_addr = 17'h00030; cpu_cs = 1'b1; rdata = 16'h2222;
        tick(12);
        chk("cL_f1_ok", 32'(c1_ok), 1);
        chk("cL_f0_ok", 32'(c0_ok), 1);
        chk("cL_dout", 32'(c1_dout), 32'h2222);
        cpu_cs = 1'b0;
        tick(1);

        // collision B: round-robin gives MCU, fixed priority gives CPU
        cpu_addr = 17'h00040; cpu_cs = 1'b1;
        mcu_addr = 17'h00050; mcu_req = 1'b1;
        rdata = 16'h3333; base1 = n1; base0 = n0;
        tick(1);
        mcu_req = 1'b0;
        chk("cB_f1_first_mcu", 32'(b1), 1);
        chk("cB_f1_addr", 32'(s1_addr), 32'h50);
        chk("cB_f0_first_cpu", 32'(b0), 0);
        chk("cB_f0_addr", 32'(s0_addr), 32'h40);
        tick(30);
        chk("cB_f1_count", 32'(n1 - base1), 2);
        chk("cB_f0_count", 32'(n0 - base0), 2);
        chk("cB_f1_second_cpu", 32'(r1_busy), 0);
        chk("cB_f0_second_mcu", 32'(r0_busy), 1);
        chk("cB_f1_cpu_ok", 32'(c1_ok), 1);
        chk("cB_f0_cpu_ok", 32'(c0_ok), 1);
        cpu_cs = 1'b0;
        tick(1);

        // CPU read-modify-write with a one-cycle cs drop
        cpu_addr = 17'h00055; cpu_rnw = 1'b1; cpu_cs = 1'b1; rdata = 16'h1234; base1 = n1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin tick(1); if (c1_ok) ok = 1'b1; end
        chk("rmw_read_ok", 32'(ok), 1);
        tick(3);
        cpu_cs = 1'b0;
        tick(1);
        cpu_rnw = 1'b0; cpu_din = 16'h5678; cpu_cs = 1'b1; rdata = 16'h9999;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin tick(1); if (c1_ok) ok = 1'b1; end
        chk("rmw_write_ok", 32'(ok), 1);
        tick(3);
        chk("rmw_count", 32'(n1 - base1), 2);
        chk("rmw_second_write", 32'(r1_rnw), 0);
        chk("rmw_din", 32'(r1_din), 32'h5678);
        chk("rmw_dout_kept", 32'(c1_dout), 32'h1234);
        cpu_cs = 1'b0;
        tick(1);

        // asynchronous reset in the middle of an MCU access
        mcu_addr = 17'h00060; mcu_rnw = 1'b1; mcu_dsn = 2'b00; mcu_req = 1'b1;
        tick(1);
        mcu_req = 1'b0;
        tick(2);
        chk("ar_busy_before", 32'(b1), 1);
        rst = 1'b1;
        #1;
        chk("ar_mem_cs", 32'(s1_cs), 0);
        chk("ar_mcu_ack", 32'(m1_ack), 0);
        chk("ar_busy", 32'(b1), 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        cpu_addr = 17'h00070; cpu_rnw = 1'b1; cpu_cs = 1'b1; rdata = 16'h4444;
        base1 = n1; ab1 = a1;
        tick(1);
        chk("ar_cpu_cs", 32'(s1_cs), 1);
        chk("ar_cpu_owner", 32'(b1), 0);
        chk("ar_cpu_addr", 32'(s1_addr), 32'h70);
        tick(20);
        chk("ar_mcu_lost", 32'(n1 - base1), 1);
        chk("ar_no_ack", 32'(a1 - ab1), 0);
        chk("ar_cpu_ok", 32'(c1_ok), 1);
        chk("ar_cpu_dout", 32'(c1_dout), 32'h4444);
        cpu_cs = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
